// File: rtl/wb_dcache_flush_pkg.sv
// rtl/wb_dcache_flush_pkg.sv - shared types and geometry for the dcache flush controller
// Purpose: FSM state type and default dcache geometry (32 KiB, 8 ways, 16 B lines).
// Ports: none (package).
package wb_dcache_flush_pkg;

  localparam int DCACHE_NUM_SETS   = 256;
  localparam int DCACHE_NUM_WAYS   = 8;
  localparam int DCACHE_LINE_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_TAG,
    WAIT_TAG,
    WB_REQ,
    WB_WAIT,
    INV_SET,
    DONE
  } flush_state_e;

endpackage

// File: rtl/wb_dcache_flush_ctrl_if.sv
// rtl/wb_dcache_flush_ctrl_if.sv - tag-array and writeback bus between flush controller and dcache
// Purpose: groups the tag-array port and the line-writeback port.
// Ports (master = flush controller):
//   tag_req_o/tag_gnt_i/tag_we_o/tag_idx_o  tag-array request, grant, write enable, set index
//   tag_rvalid_i/tag_valid_i/tag_dirty_i    tag read response, one cycle after a read grant
//   wb_req_o/wb_gnt_i/wb_way_o/wb_idx_o     writeback request, grant, way, set index
//   wb_done_i                               writeback completion
interface wb_dcache_flush_ctrl_if
  import wb_dcache_flush_pkg::*;
#(
  parameter int NumSets = DCACHE_NUM_SETS,
  parameter int NumWays = DCACHE_NUM_WAYS
) ();

  localparam int IdxW = $clog2(NumSets);
  localparam int WayW = $clog2(NumWays);

  logic               tag_req_o;
  logic               tag_gnt_i;
  logic               tag_we_o;
  logic [IdxW-1:0]    tag_idx_o;
  logic               tag_rvalid_i;
  logic [NumWays-1:0] tag_valid_i;
  logic [NumWays-1:0] tag_dirty_i;
  logic               wb_req_o;
  logic               wb_gnt_i;
  logic [WayW-1:0]    wb_way_o;
  logic [IdxW-1:0]    wb_idx_o;
  logic               wb_done_i;

  modport master (
    output tag_req_o, tag_we_o, tag_idx_o, wb_req_o, wb_way_o, wb_idx_o,
    input  tag_gnt_i, tag_rvalid_i, tag_valid_i, tag_dirty_i, wb_gnt_i, wb_done_i
  );

  modport slave (
    input  tag_req_o, tag_we_o, tag_idx_o, wb_req_o, wb_way_o, wb_idx_o,
    output tag_gnt_i, tag_rvalid_i, tag_valid_i, tag_dirty_i, wb_gnt_i, wb_done_i
  );

endinterface

// File: rtl/wb_flush_way_sel.sv
// rtl/wb_flush_way_sel.sv - lowest-set-bit way selector
// Purpose: picks the lowest-numbered way in a pending mask.
// Ports: mask_i (NumWays) in; way_o (index of lowest set bit, 0 if none) out; empty_o (mask is zero) out.
module wb_flush_way_sel #(
  parameter  int NumWays = 8,
  localparam int WayW    = $clog2(NumWays)
) (
  input  logic [NumWays-1:0] mask_i,
  output logic [WayW-1:0]    way_o,
  output logic               empty_o
);

  always_comb begin
    way_o   = '0;
    empty_o = ~|mask_i;
    // Scan from the top so the lowest set bit is the last write.
    for (int i = NumWays - 1; i >= 0; i--) begin
      if (mask_i[i]) way_o = WayW'(i);
    end
  end

endmodule

// File: rtl/wb_dcache_flush_ctrl.sv
// rtl/wb_dcache_flush_ctrl.sv - write-back dcache flush controller
// Purpose: walks every set in ascending order, writes back valid+dirty lines
//   lowest way first, then invalidates the set; pulses flush_ack_o at the end.
// Ports: clk_i, rst_i (sync, active-high); flush_i request; flush_ack_o one-cycle
//   completion pulse; busy_o high outside IDLE; wb_cnt_o dirty lines written back;
//   bus (wb_dcache_flush_ctrl_if.master) tag-array and writeback ports.
// Config: define WB_FLUSH_PERF_CNT_EN to build the wb_cnt_o counter; otherwise it reads 0.
module wb_dcache_flush_ctrl
  import wb_dcache_flush_pkg::*;
#(
  parameter int NumSets = DCACHE_NUM_SETS,
  parameter int NumWays = DCACHE_NUM_WAYS
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  output logic                          flush_ack_o,
  output logic                          busy_o,
  output logic [15:0]                   wb_cnt_o,
  wb_dcache_flush_ctrl_if.master        bus
);

  localparam int IdxW = $clog2(NumSets);
  localparam int WayW = $clog2(NumWays);

  flush_state_e       state_q;
  logic [IdxW-1:0]    set_q;
  logic [NumWays-1:0] pending_q;
  logic               tag_req_q;
  logic               tag_we_q;
  logic               wb_req_q;
  logic [WayW-1:0]    wb_way_q;
  logic               ack_q;
  logic               busy_q;

  // Next pending mask: the fresh tag read in WAIT_TAG, otherwise the current
  // mask minus the way just written back. One selector serves both cases.
  logic [NumWays-1:0] pend_src;
  logic [WayW-1:0]    sel_way;
  logic               sel_empty;

  always_comb begin
    pend_src = pending_q & ~(NumWays'(1) << wb_way_q);
    if (state_q == WAIT_TAG) pend_src = bus.tag_valid_i & bus.tag_dirty_i;
  end

  wb_flush_way_sel #(.NumWays(NumWays)) u_way_sel (
    .mask_i  (pend_src),
    .way_o   (sel_way),
    .empty_o (sel_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      set_q     <= '0;
      pending_q <= '0;
      tag_req_q <= 1'b0;
      tag_we_q  <= 1'b0;
      wb_req_q  <= 1'b0;
      wb_way_q  <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flush_i) begin
            set_q     <= '0;
            tag_req_q <= 1'b1;
            tag_we_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= RD_TAG;
          end
        end
        RD_TAG: begin
          if (bus.tag_gnt_i) begin
            tag_req_q <= 1'b0;
            state_q   <= WAIT_TAG;
          end
        end
        WAIT_TAG, WB_WAIT: begin
          if ((state_q == WAIT_TAG && bus.tag_rvalid_i) ||
              (state_q == WB_WAIT && bus.wb_done_i)) begin
            pending_q <= pend_src;
            if (!sel_empty) begin
              wb_req_q <= 1'b1;
              wb_way_q <= sel_way;
              state_q  <= WB_REQ;
            end else begin
              tag_req_q <= 1'b1;
              tag_we_q  <= 1'b1;
              state_q   <= INV_SET;
            end
          end
        end
        WB_REQ: begin
          if (bus.wb_gnt_i) begin
            wb_req_q <= 1'b0;
            state_q  <= WB_WAIT;
          end
        end
        INV_SET: begin
          if (bus.tag_gnt_i) begin
            tag_we_q <= 1'b0;
            if (set_q == IdxW'(NumSets - 1)) begin
              tag_req_q <= 1'b0;
              ack_q     <= 1'b1;
              state_q   <= DONE;
            end else begin
              set_q     <= set_q + 1'b1;
              tag_req_q <= 1'b1;
              state_q   <= RD_TAG;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WB_FLUSH_PERF_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && flush_i) begin
      cnt_q <= '0;
    end else if (state_q == WB_WAIT && bus.wb_done_i && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign wb_cnt_o = cnt_q;
`else
  assign wb_cnt_o = 16'd0;
`endif

  assign flush_ack_o   = ack_q;
  assign busy_o        = busy_q;
  assign bus.tag_req_o = tag_req_q;
  assign bus.tag_we_o  = tag_we_q;
  assign bus.tag_idx_o = set_q;
  assign bus.wb_req_o  = wb_req_q;
  assign bus.wb_way_o  = wb_way_q;
  assign bus.wb_idx_o  = set_q;

endmodule

// File: tb/tb_wb_dcache_flush_ctrl.sv
// tb/tb_wb_dcache_flush_ctrl.sv - self-checking bench for wb_dcache_flush_ctrl
module tb_wb_dcache_flush_ctrl;

  localparam int NUM_SETS = 256;
  localparam int NUM_WAYS = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        flush_ack_o;
  logic        busy_o;
  logic [15:0] wb_cnt_o;

  wb_dcache_flush_ctrl_if #(.NumSets(NUM_SETS), .NumWays(NUM_WAYS)) bus ();

  wb_dcache_flush_ctrl #(.NumSets(NUM_SETS), .NumWays(NUM_WAYS)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .flush_ack_o (flush_ack_o),
    .busy_o      (busy_o),
    .wb_cnt_o    (wb_cnt_o),
    .bus         (bus.master)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;

  // Cache contents as the dcache would hold them.
  logic [7:0] valid_mem [NUM_SETS];
  logic [7:0] dirty_mem [NUM_SETS];

  // Expected event stream: read tag, write back each valid+dirty way, invalidate.
  int exp_q[$];
  int wb_log[$];

  int ack_cnt = 0, ack_cyc = 0, done_cnt = 0, wb_req_seen = 0, last_wb_idx = -1;
  int tag_left = 0, wb_left = 0, done_cd = -1;
  int tag_wait_max = 0, wb_wait_max = 0, done_wait_max = 0;
  int hold_rd_idx = -1, hold_rd_cycles = 0, hold_wb_cycles = -1;
  bit spur_done = 0, spur_rv = 0;

  function automatic int enc(input int k, input int s, input int w);
    return (k << 16) | (s << 4) | w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_ev(input string tag, input int obs);
    int e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk(tag, obs, e);
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int s = 0; s < NUM_SETS; s++) begin
      exp_q.push_back(enc(0, s, 0));
      for (int w = 0; w < NUM_WAYS; w++)
        if (valid_mem[s][w] && dirty_mem[s][w]) exp_q.push_back(enc(1, s, w));
      exp_q.push_back(enc(2, s, 0));
    end
  endtask

  task automatic step();
    logic p_rst, p_tag_req, p_tag_gnt, p_tag_we, p_wb_req, p_wb_gnt;
    logic [7:0] p_idx, p_wb_idx;
    logic [2:0] p_way;
    p_rst = rst_i;
    p_tag_req = bus.tag_req_o; p_tag_gnt = bus.tag_gnt_i; p_tag_we = bus.tag_we_o;
    p_idx = bus.tag_idx_o;
    p_wb_req = bus.wb_req_o; p_wb_gnt = bus.wb_gnt_i; p_way = bus.wb_way_o;
    p_wb_idx = bus.wb_idx_o;
    @(posedge clk_i);
    #1;
    cyc++;
    bus.tag_rvalid_i = 1'b0;
    bus.tag_valid_i  = 8'($urandom);
    bus.tag_dirty_i  = 8'($urandom);
    bus.wb_done_i    = 1'b0;
    if (p_rst) begin
      done_cd = -1;
    end else begin
      if (p_tag_req && p_tag_gnt) begin
        if (p_tag_we) begin
          expect_ev("inv_set", enc(2, int'(p_idx), 0));
          valid_mem[p_idx] = 8'h00;
          dirty_mem[p_idx] = 8'h00;
        end else begin
          expect_ev("rd_tag", enc(0, int'(p_idx), 0));
          bus.tag_rvalid_i = 1'b1;
          bus.tag_valid_i  = valid_mem[p_idx];
          bus.tag_dirty_i  = dirty_mem[p_idx];
        end
      end
      if (p_wb_req && p_wb_gnt) begin
        expect_ev("wb_line", enc(1, int'(p_wb_idx), int'(p_way)));
        if (p_wb_idx == 8'd5) wb_log.push_back(int'(p_way));
        last_wb_idx = int'(p_wb_idx);
        done_cd = $urandom_range(0, done_wait_max);
      end
      if (p_tag_req && !p_tag_gnt)
        chk("tag_req_hold", {bus.tag_req_o, bus.tag_we_o, bus.tag_idx_o}, {1'b1, p_tag_we, p_idx});
      if (p_wb_req && !p_wb_gnt)
        chk("wb_req_hold", {bus.wb_req_o, bus.wb_way_o, bus.wb_idx_o}, {1'b1, p_way, p_wb_idx});
    end
    chk("req_exclusive", 32'(bus.tag_req_o & bus.wb_req_o), 0);
    if (bus.wb_req_o) begin
      wb_req_seen++;
      chk("wb_idx_eq_tag_idx", 32'(bus.wb_idx_o), 32'(bus.tag_idx_o));
    end
    if (flush_ack_o) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
    if (done_cd == 0) begin
      bus.wb_done_i = 1'b1;
      done_cnt++;
      done_cd = -1;
    end else if (done_cd > 0) begin
      done_cd--;
    end else if (spur_done && bus.tag_req_o && !bus.tag_we_o) begin
      bus.wb_done_i = 1'b1;
    end
    if (!bus.tag_rvalid_i && spur_rv && bus.tag_req_o && bus.tag_we_o) begin
      bus.tag_rvalid_i = 1'b1;
      bus.tag_valid_i  = 8'hFF;
      bus.tag_dirty_i  = 8'hFF;
    end
    if (bus.tag_req_o) begin
      if (p_rst || !(p_tag_req && !p_tag_gnt)) begin
        if (!bus.tag_we_o && int'(bus.tag_idx_o) == hold_rd_idx) tag_left = hold_rd_cycles;
        else tag_left = $urandom_range(0, tag_wait_max);
      end
      bus.tag_gnt_i = (tag_left == 0);
      if (tag_left > 0) tag_left--;
    end else begin
      bus.tag_gnt_i = 1'($urandom_range(0, 1));
    end
    if (bus.wb_req_o) begin
      if (p_rst || !(p_wb_req && !p_wb_gnt))
        wb_left = (hold_wb_cycles >= 0) ? hold_wb_cycles : $urandom_range(0, wb_wait_max);
      bus.wb_gnt_i = (wb_left == 0);
      if (wb_left > 0) wb_left--;
    end else begin
      bus.wb_gnt_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_flush(input bit hold);
    build_exp();
    done_cnt = 0;
    wb_req_seen = 0;
    flush_i = 1'b1;
    step();
    c0 = cyc;
    if (!hold) flush_i = 1'b0;
    chk("start_busy", 32'(busy_o), 1);
    chk("start_rd_set0", {bus.tag_req_o, bus.tag_we_o, bus.tag_idx_o}, {1'b1, 1'b0, 8'd0});
  endtask

  task automatic finish_flush(input int exp_lat);
    int a0;
    a0 = ack_cnt;
    for (int i = 0; i < 8000 && ack_cnt == a0; i++) step();
    chk("ack_seen", ack_cnt - a0, 1);
    if (exp_lat > 0) chk("ack_latency", ack_cyc - c0 + 1, exp_lat);
    chk("events_left", exp_q.size(), 0);
`ifdef WB_FLUSH_PERF_CNT_EN
    chk("wb_cnt_at_ack", 32'(wb_cnt_o), done_cnt);
`else
    chk("wb_cnt_at_ack", 32'(wb_cnt_o), 0);
`endif
    step();
    chk("ack_one_cycle", {flush_ack_o, busy_o}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {flush_ack_o, busy_o, bus.tag_req_o, bus.tag_we_o, bus.wb_req_o}, 0);
    chk({tag, "_idx"}, {bus.tag_idx_o, bus.wb_idx_o, bus.wb_way_o}, 0);
    chk({tag, "_cnt"}, 32'(wb_cnt_o), 0);
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    bus.tag_gnt_i = 1'b0; bus.tag_rvalid_i = 1'b0;
    bus.tag_valid_i = '0; bus.tag_dirty_i = '0;
    bus.wb_gnt_i = 1'b0; bus.wb_done_i = 1'b0;

    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    rst_i = 1'b0;
    step();
    check_all_zero("idle");

    // Clean cache, immediate grants, spurious wb_done / rvalid ignored
    for (int s = 0; s < NUM_SETS; s++) begin
      valid_mem[s] = 8'($urandom);
      dirty_mem[s] = 8'h00;
    end
    spur_done = 1; spur_rv = 1;
    start_flush(0);
    finish_flush(3 * NUM_SETS + 1);
    chk("clean_no_wb_req", wb_req_seen, 0);
    chk("clean_wb_cnt", 32'(wb_cnt_o), 0);
    spur_done = 0; spur_rv = 0;

    // Set 5 with three dirty ways; withheld tag and wb grants
    for (int s = 0; s < NUM_SETS; s++) begin
      valid_mem[s] = 8'h00;
      dirty_mem[s] = 8'h00;
    end
    valid_mem[5] = 8'hFF; dirty_mem[5] = 8'b1010_0001;
    valid_mem[6] = 8'h0F; dirty_mem[6] = 8'hF0;
    hold_rd_idx = 5; hold_rd_cycles = 10; hold_wb_cycles = 4; done_wait_max = 2;
    wb_log.delete();
    start_flush(0);
    finish_flush(-1);
    chk("set5_wb_count", wb_log.size(), 3);
    if (wb_log.size() == 3) begin
      chk("set5_way0", wb_log[0], 0);
      chk("set5_way1", wb_log[1], 5);
      chk("set5_way2", wb_log[2], 7);
    end
    hold_rd_idx = -1; hold_wb_cycles = -1;

    // Randomized contents and handshake timing
    tag_wait_max = 2; wb_wait_max = 2; done_wait_max = 3;
    repeat (2) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_mem[s] = 8'($urandom);
        dirty_mem[s] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      end
      start_flush(0);
      finish_flush(-1);
    end

    // Reset while waiting for a writeback at set 100
    for (int s = 0; s < NUM_SETS; s++) begin
      valid_mem[s] = 8'($urandom);
      dirty_mem[s] = 8'h00;
    end
    valid_mem[100] = 8'hFF; dirty_mem[100] = 8'h10;
    valid_mem[150] = 8'h03; dirty_mem[150] = 8'h03;
    done_wait_max = 3;
    last_wb_idx = -1;
    start_flush(0);
    for (int i = 0; i < 4000 && last_wb_idx != 100; i++) step();
    chk("reach_set100_wb", last_wb_idx, 100);
    begin
      int a0;
      a0 = ack_cnt;
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check_all_zero("abort");
      repeat (20) step();
      chk("abort_no_ack", ack_cnt - a0, 0);
      chk("abort_idle", 32'(busy_o), 0);
    end
    start_flush(0);
    finish_flush(-1);

    // flush_i held through DONE: exactly one further flush; spurious wb_done in RD_TAG
    for (int s = 0; s < NUM_SETS; s++) begin
      valid_mem[s] = 8'($urandom);
      dirty_mem[s] = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
    end
    spur_done = 1;
    start_flush(1);
    finish_flush(-1);
    start_flush(0);
    finish_flush(-1);
    repeat (5) step();
    chk("held_flush_single_restart", 32'(busy_o), 0);
    spur_done = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_dcache_flush_ctrl.md
WB_DCACHE_FLUSH_CTRL -- requirements
Module: wb_dcache_flush_ctrl

Interface
REQ-001 SHALL have parameter NumSets, default 256, number of dcache sets (32 KiB / 8 ways / 16 B lines).
REQ-002 SHALL have parameter NumWays, default 8, dcache associativity.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port flush_i, input, 1: flush request (fence / CSR), sampled only in IDLE.
REQ-006 SHALL have port flush_ack_o, output, 1: one-cycle pulse on flush completion.
REQ-007 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-008 SHALL have ports tag_req_o (output, 1), tag_gnt_i (input, 1), tag_we_o (output, 1), tag_idx_o (output, $clog2(NumSets)): tag-array port request, grant, write-enable, set index.
REQ-009 SHALL have ports tag_rvalid_i (input, 1), tag_valid_i (input, NumWays), tag_dirty_i (input, NumWays): tag read response, one cycle after grant.
REQ-010 SHALL have ports wb_req_o (output, 1), wb_gnt_i (input, 1), wb_way_o (output, $clog2(NumWays)), wb_done_i (input, 1): line-writeback request to the miss unit; wb_idx_o equals tag_idx_o.
REQ-011 SHALL have port wb_cnt_o, output, 16: dirty lines written back in the current/last flush.

Function
REQ-012 SHALL implement FSM states IDLE, RD_TAG, WAIT_TAG, WB_REQ, WB_WAIT, INV_SET, DONE.
REQ-013 SHALL in IDLE with flush_i=1 clear set counter to 0 and enter RD_TAG next cycle; flush_i ignored in all other states.
REQ-014 SHALL in RD_TAG drive tag_req_o=1, tag_we_o=0, holding request until tag_gnt_i; on grant enter WAIT_TAG.
REQ-015 SHALL in WAIT_TAG on tag_rvalid_i latch pending = tag_valid_i & tag_dirty_i; enter WB_REQ if pending nonzero, else INV_SET.
REQ-016 SHALL in WB_REQ drive wb_req_o=1 with wb_way_o = lowest set bit of pending, held stable until wb_gnt_i, then enter WB_WAIT.
REQ-017 SHALL in WB_WAIT on wb_done_i clear that way's pending bit, increment wb_cnt_o (saturate at 16'hFFFF), go to WB_REQ if pending still nonzero else INV_SET.
REQ-018 SHALL in INV_SET drive tag_req_o=1, tag_we_o=1 (all ways valid=0, dirty=0) until tag_gnt_i; on grant go to DONE if set==NumSets-1, else increment set and go to RD_TAG.
REQ-019 SHALL in DONE assert flush_ack_o for exactly one cycle and return to IDLE.
REQ-020 SHALL keep tag_req_o and wb_req_o never high in the same cycle.
REQ-021 SHALL ignore wb_done_i outside WB_WAIT and tag_rvalid_i outside WAIT_TAG.
REQ-022 SHALL process sets strictly in ascending order 0..NumSets-1; minimum latency for a clean cache with immediate grants is 3*NumSets+1 cycles from flush_i to flush_ack_o.

Reset
REQ-023 SHALL on rst_i=1 force IDLE, set counter 0, pending 0, wb_cnt_o 0, and all outputs 0; reset mid-flush aborts without flush_ack_o.

Configuration
REQ-024 SHALL with macro WB_FLUSH_PERF_CNT_EN defined implement wb_cnt_o per REQ-017, cleared on flush start.
REQ-025 SHALL without WB_FLUSH_PERF_CNT_EN tie wb_cnt_o to 0 and instantiate no counter flops; port list unchanged.

Structure
REQ-026 SHALL place the FSM state typedef and constants DCACHE_NUM_SETS=256, DCACHE_NUM_WAYS=8, DCACHE_LINE_BYTES=16 in shared package wb_dcache_flush_pkg.
REQ-027 SHALL implement lowest-set-bit selection in sub-module wb_flush_way_sel (NumWays-bit mask in, way index and empty flag out).

Verification
REQ-028 SHALL cover: all lines clean, grants tied high, flush_i pulse -> 256 RD/INV pairs, flush_ack_o at cycle 769, wb_req_o never asserted, wb_cnt_o=0.
REQ-029 SHALL cover: set 5 valid=8'hFF dirty=8'b1010_0001 -> wb_way_o sequence 0,5,7 at idx 5, then INV_SET idx 5, wb_cnt_o=3 at ack.
REQ-030 SHALL cover: tag_gnt_i withheld 10 cycles in RD_TAG and wb_gnt_i withheld 4 cycles in WB_REQ -> request and index/way stable throughout, no state advance.
REQ-031 SHALL cover: rst_i asserted in WB_WAIT at set 100 -> next cycle IDLE, all outputs 0, no flush_ack_o; new flush restarts at set 0.
REQ-032 SHALL cover: flush_i held high through DONE -> exactly one new flush begins after return to IDLE; spurious wb_done_i in RD_TAG has no effect.
